// File: rtl/riscv_pkg.sv
// Shared core definitions: default datapath width and the
// memory-port arbiter state encoding.
package riscv_pkg;

    localparam int XLEN_DEF = 32;

    localparam logic [1:0] ST_IDLE    = 2'b00;
    localparam logic [1:0] ST_IF_BUSY = 2'b01;
    localparam logic [1:0] ST_DM_BUSY = 2'b10;
    localparam logic [1:0] ST_RESP    = 2'b11;

    typedef enum logic [1:0] {
        IDLE    = ST_IDLE,
        IF_BUSY = ST_IF_BUSY,
        DM_BUSY = ST_DM_BUSY,
        RESP    = ST_RESP
    } arb_state_e;

endpackage

// File: rtl/bus_watchdog.sv
// Busy-cycle counter: flags expiry on the TIMEOUT-th busy cycle
// that has passed without a memory ready.
module bus_watchdog #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic busy,
    input  logic ready,
    output logic expired
);

    logic [7:0] r_cnt;
    logic       w_wait;

    assign w_wait  = busy & ~ready;
    assign expired = w_wait & (r_cnt == 8'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= 8'd0;
        end else if (clear) begin
            r_cnt <= 8'd0;
        end else if (w_wait) begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and data
// access; data wins ties, with a watchdog abort on a stuck memory.
module mem_port_arbiter
    import riscv_pkg::*;
#(
    parameter int XLEN    = XLEN_DEF,
    parameter int TIMEOUT = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            if_req,
    input  logic [XLEN-1:0] if_addr,
    output logic [XLEN-1:0] if_rdata,
    output logic            if_valid,
    input  logic            dm_read,
    input  logic            dm_write,
    input  logic [XLEN-1:0] dm_addr,
    input  logic [XLEN-1:0] dm_wdata,
    output logic [XLEN-1:0] dm_rdata,
    output logic            dm_done,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            mem_ready,
    output logic            stall,
    output logic            err
);

    arb_state_e      r_state;
    arb_state_e      w_next;
    logic            r_is_dm;
    logic            r_err;
    logic            r_we;
    logic [XLEN-1:0] r_addr;
    logic [XLEN-1:0] r_wdata;
    logic [XLEN-1:0] r_if_rdata;
    logic [XLEN-1:0] r_dm_rdata;
    logic            w_dm_req;
    logic            w_busy;
    logic            w_grant;
    logic            w_expired;
    logic            w_finish;
    logic [XLEN-1:0] w_cap;

    assign w_dm_req = dm_read | dm_write;
    assign w_busy   = (r_state == IF_BUSY) | (r_state == DM_BUSY);
    assign w_grant  = (r_state == IDLE) & (w_dm_req | if_req);
    assign w_finish = w_busy & (mem_ready | w_expired);
    // An aborted access returns zero rather than bus garbage
    assign w_cap    = mem_ready ? mem_rdata : '0;

    bus_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (w_grant),
        .busy    (w_busy),
        .ready   (mem_ready),
        .expired (w_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_dm_req) begin
                    w_next = DM_BUSY;
                end else if (if_req) begin
                    w_next = IF_BUSY;
                end
            end
            IF_BUSY, DM_BUSY: begin
                if (mem_ready | w_expired) begin
                    w_next = RESP;
                end
            end
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_is_dm    <= 1'b0;
            r_err      <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_if_rdata <= '0;
            r_dm_rdata <= '0;
        end else begin
            if (r_state == IDLE) begin
                if (w_dm_req) begin
                    r_is_dm <= 1'b1;
                    r_err   <= 1'b0;
                    r_we    <= dm_write;
                    r_addr  <= dm_addr;
                    r_wdata <= dm_wdata;
                end else if (if_req) begin
                    r_is_dm <= 1'b0;
                    r_err   <= 1'b0;
                    r_we    <= 1'b0;
                    r_addr  <= if_addr;
                    r_wdata <= '0;
                end
            end
            if (w_finish) begin
                r_err <= ~mem_ready;
                if (r_state == IF_BUSY) begin
                    r_if_rdata <= w_cap;
                end else if (!r_we) begin
                    r_dm_rdata <= w_cap;
                end
            end
        end
    end

    assign mem_req   = w_busy;
    assign mem_we    = r_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign if_rdata  = r_if_rdata;
    assign dm_rdata  = r_dm_rdata;
    assign if_valid  = (r_state == RESP) & ~r_is_dm;
    assign dm_done   = (r_state == RESP) & r_is_dm;
    assign err       = (r_state == RESP) & r_err;
    assign stall     = (w_dm_req & ~dm_done) | (if_req & ~if_valid);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with a wait-state
// programmable memory responder.
module tb_mem_port_arbiter;

    localparam int XLEN = 32;
    localparam int TO   = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            if_req = 1'b0;
    logic [XLEN-1:0] if_addr = '0;
    logic [XLEN-1:0] if_rdata;
    logic            if_valid;
    logic            dm_read = 1'b0;
    logic            dm_write = 1'b0;
    logic [XLEN-1:0] dm_addr = '0;
    logic [XLEN-1:0] dm_wdata = '0;
    logic [XLEN-1:0] dm_rdata;
    logic            dm_done;
    logic            mem_req;
    logic            mem_we;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_wdata;
    logic [XLEN-1:0] mem_rdata = '0;
    logic            mem_ready = 1'b0;
    logic            stall;
    logic            err;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .XLEN    (XLEN),
        .TIMEOUT (TO)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_valid  (if_valid),
        .dm_read   (dm_read),
        .dm_write  (dm_write),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_rdata  (dm_rdata),
        .dm_done   (dm_done),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .stall     (stall),
        .err       (err)
    );

    typedef struct {
        logic            is_dm;
        logic [XLEN-1:0] rdata;
        logic            err;
    } exp_t;

    exp_t            sb[$];
    int              n_chk = 0;
    int              n_fail = 0;
    int              cyc = 0;
    int              cur_wait = 0;
    int              wait_n = 0;
    logic            idle_ready = 1'b0;
    logic [XLEN-1:0] mem_base = '0;
    logic [XLEN-1:0] exp_dm_rd = '0;
    logic [XLEN-1:0] exp_if_rd = '0;

    // Advance one cycle, score any completion pulse, then set up
    // the memory response for the cycle just entered.
    task automatic step();
        exp_t            e;
        logic [XLEN-1:0] got;
        @(posedge clk);
        #1;
        cyc++;
        if (if_valid || dm_done) begin
            n_chk++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected if_valid=%0b dm_done=%0b required no pulse",
                         if_valid, dm_done);
            end else begin
                e   = sb.pop_front();
                got = e.is_dm ? dm_rdata : if_rdata;
                if (dm_done !== e.is_dm || if_valid !== ~e.is_dm ||
                    got !== e.rdata || err !== e.err) begin
                    n_fail++;
                    $display("FAIL sb_resp dm_done=%0b if_valid=%0b rdata=%h err=%0b required dm=%0b rdata=%h err=%0b",
                             dm_done, if_valid, got, err, e.is_dm, e.rdata, e.err);
                end
            end
        end
        if (mem_req) begin
            mem_ready = (cur_wait >= wait_n);
            cur_wait++;
        end else begin
            mem_ready = idle_ready;
            cur_wait = 0;
        end
        mem_rdata = mem_base ^ mem_addr;
    endtask

    task automatic push(input logic is_dm, input logic [XLEN-1:0] rd,
                        input logic e_err);
        exp_t e;
        e.is_dm = is_dm;
        e.rdata = rd;
        e.err   = e_err;
        sb.push_back(e);
    endtask

    task automatic test_reset();
        step();
        step();
        n_chk++;
        if ({mem_req, mem_we, if_valid, dm_done, err, stall} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl got=%b required=000000",
                     {mem_req, mem_we, if_valid, dm_done, err, stall});
        end
        n_chk++;
        if (mem_addr !== '0 || mem_wdata !== '0) begin
            n_fail++;
            $display("FAIL reset_mem addr=%h wdata=%h required 0",
                     mem_addr, mem_wdata);
        end
        n_chk++;
        if (if_rdata !== '0 || dm_rdata !== '0) begin
            n_fail++;
            $display("FAIL reset_rdata if=%h dm=%h required 0",
                     if_rdata, dm_rdata);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_idle_ready();
        idle_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            n_chk++;
            if (mem_req !== 1'b0) begin
                n_fail++;
                $display("FAIL idle_ready mem_req=%b required 0", mem_req);
            end
        end
        idle_ready = 1'b0;
        step();
    endtask

    task automatic test_load_vs_fetch();
        int  t_dm;
        int  t_if;
        logic seen;
        t_dm = -1;
        t_if = -1;
        seen = 1'b0;
        wait_n = 0;
        mem_base = 32'hDEADBEEF ^ 32'h100;
        dm_read = 1'b1;
        dm_addr = 32'h100;
        if_req  = 1'b1;
        if_addr = 32'h0;
        exp_dm_rd = 32'hDEADBEEF;
        push(1'b1, exp_dm_rd, 1'b0);
        exp_if_rd = mem_base ^ 32'h0;
        push(1'b0, exp_if_rd, 1'b0);
        for (int k = 0; k < 30; k++) begin
            step();
            if (mem_req && !seen) begin
                seen = 1'b1;
                n_chk++;
                if (mem_addr !== 32'h100 || mem_we !== 1'b0) begin
                    n_fail++;
                    $display("FAIL lvf_first_grant addr=%h we=%b required 100/0",
                             mem_addr, mem_we);
                end
            end
            if (dm_done) begin
                t_dm = cyc;
                n_chk++;
                if (stall !== 1'b1) begin
                    n_fail++;
                    $display("FAIL lvf_stall_dm stall=%b required 1", stall);
                end
                dm_read = 1'b0;
            end
            if (if_valid) begin
                t_if = cyc;
                n_chk++;
                if (stall !== 1'b0) begin
                    n_fail++;
                    $display("FAIL lvf_stall_if stall=%b required 0", stall);
                end
                if_req = 1'b0;
                break;
            end
        end
        n_chk++;
        if (t_dm < 0 || t_if - t_dm != 3) begin
            n_fail++;
            $display("FAIL lvf_spacing dm=%0d if=%0d required if-dm=3",
                     t_dm, t_if);
        end
        dm_read = 1'b0;
        if_req = 1'b0;
        step();
    endtask

    task automatic test_store_wait();
        int   busy;
        logic done;
        busy = 0;
        done = 1'b0;
        wait_n = 2;
        mem_base = 32'h55550000;
        dm_write = 1'b1;
        dm_addr  = 32'h40;
        dm_wdata = 32'h12345678;
        push(1'b1, exp_dm_rd, 1'b0);
        for (int k = 0; k < 30; k++) begin
            step();
            if (mem_req) begin
                busy++;
                n_chk++;
                if (mem_we !== 1'b1 || mem_addr !== 32'h40 ||
                    mem_wdata !== 32'h12345678) begin
                    n_fail++;
                    $display("FAIL store_hold we=%b addr=%h wdata=%h required 1/40/12345678",
                             mem_we, mem_addr, mem_wdata);
                end
            end
            if (dm_done) begin
                done = 1'b1;
                dm_write = 1'b0;
                break;
            end
        end
        n_chk++;
        if (!done || busy != 3) begin
            n_fail++;
            $display("FAIL store_busy done=%b busy=%0d required 1/3", done, busy);
        end
        dm_write = 1'b0;
        step();
    endtask

    task automatic test_timeout();
        int   busy;
        logic done;
        busy = 0;
        done = 1'b0;
        wait_n = 1000;
        mem_base = 32'hFFFF0000;
        if_req  = 1'b1;
        if_addr = 32'h200;
        exp_if_rd = '0;
        push(1'b0, exp_if_rd, 1'b1);
        for (int k = 0; k < 30; k++) begin
            step();
            if (mem_req) busy++;
            if (if_valid) begin
                done = 1'b1;
                if_req = 1'b0;
                break;
            end
        end
        n_chk++;
        if (!done || busy != TO) begin
            n_fail++;
            $display("FAIL timeout_busy done=%b busy=%0d required 1/%0d",
                     done, busy, TO);
        end
        if_req = 1'b0;
        step();
    endtask

    task automatic test_reset_mid();
        logic done;
        done = 1'b0;
        wait_n = 1000;
        dm_read = 1'b1;
        dm_addr = 32'h80;
        for (int k = 0; k < 5; k++) begin
            step();
            if (mem_req) break;
        end
        step();
        #2;
        rst_n = 1'b0;
        #1;
        n_chk++;
        if (mem_req !== 1'b0 || mem_addr !== '0) begin
            n_fail++;
            $display("FAIL rst_mid_async mem_req=%b addr=%h required 0/0",
                     mem_req, mem_addr);
        end
        exp_dm_rd = '0;
        exp_if_rd = '0;
        step();
        step();
        n_chk++;
        if (mem_req !== 1'b0 || dm_done !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_held mem_req=%b dm_done=%b required 0/0",
                     mem_req, dm_done);
        end
        cur_wait = 0;
        wait_n = 0;
        mem_base = 32'h0BAD0000;
        exp_dm_rd = mem_base ^ 32'h80;
        push(1'b1, exp_dm_rd, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        n_chk++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h80) begin
            n_fail++;
            $display("FAIL rst_mid_grant mem_req=%b addr=%h required 1/80",
                     mem_req, mem_addr);
        end
        for (int k = 0; k < 10; k++) begin
            step();
            if (dm_done) begin
                done = 1'b1;
                break;
            end
        end
        n_chk++;
        if (!done) begin
            n_fail++;
            $display("FAIL rst_mid_done dm_done never seen, required within 10");
        end
        dm_read = 1'b0;
        step();
    endtask

    task automatic test_back_to_back();
        int idx;
        int last;
        idx = 0;
        last = -1;
        wait_n = 0;
        mem_base = 32'h600D0000;
        if_req  = 1'b1;
        if_addr = 32'h0;
        for (int i = 0; i < 3; i++) begin
            exp_if_rd = mem_base ^ XLEN'(4 * i);
            push(1'b0, exp_if_rd, 1'b0);
        end
        for (int k = 0; k < 40; k++) begin
            step();
            if (if_valid) begin
                n_chk++;
                if (stall !== 1'b0) begin
                    n_fail++;
                    $display("FAIL b2b_stall_valid stall=%b required 0", stall);
                end
                if (idx > 0) begin
                    n_chk++;
                    if (cyc - last != 3) begin
                        n_fail++;
                        $display("FAIL b2b_spacing gap=%0d required 3",
                                 cyc - last);
                    end
                end
                last = cyc;
                idx++;
                if (idx == 3) begin
                    if_req = 1'b0;
                    break;
                end
                if_addr = XLEN'(4 * idx);
            end else begin
                n_chk++;
                if (stall !== 1'b1) begin
                    n_fail++;
                    $display("FAIL b2b_stall_wait stall=%b required 1", stall);
                end
            end
        end
        n_chk++;
        if (idx != 3) begin
            n_fail++;
            $display("FAIL b2b_count got=%0d required 3", idx);
        end
        if_req = 1'b0;
        step();
    endtask

    task automatic test_rw_both();
        logic seen;
        seen = 1'b0;
        wait_n = 0;
        mem_base = 32'h77770000;
        dm_read  = 1'b1;
        dm_write = 1'b1;
        dm_addr  = 32'h300;
        dm_wdata = 32'hA5A5A5A5;
        push(1'b1, exp_dm_rd, 1'b0);
        for (int k = 0; k < 10; k++) begin
            step();
            if (mem_req) begin
                seen = 1'b1;
                n_chk++;
                if (mem_we !== 1'b1 || mem_wdata !== 32'hA5A5A5A5) begin
                    n_fail++;
                    $display("FAIL rw_both we=%b wdata=%h required 1/A5A5A5A5",
                             mem_we, mem_wdata);
                end
            end
            if (dm_done) break;
        end
        n_chk++;
        if (!seen) begin
            n_fail++;
            $display("FAIL rw_both_grant mem_req never seen, required grant");
        end
        dm_read  = 1'b0;
        dm_write = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_idle_ready();
        test_load_vs_fetch();
        test_store_wait();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        test_rw_both();
        for (int k = 0; k < 4; k++) step();
        n_chk++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain pending=%0d required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
